column_rasterizer: RTL and testbench

- Receives per-column ray results from the DDA-out FIFO over an AXI-stream style handshake.
- Expands each column record into SCREEN_HEIGHT pixel writes for the frame buffer: ceiling, then wall, then floor, one pixel per cycle.
- Sits between the DDA-out FIFO receiver port and the frame buffer write port (address, pixel, last-pixel).
- Marks frame completion with a one-cycle last-pixel pulse.

---
 rtl/rc_pkg.sv | 39 +++
 rtl/column_shader.sv | 40 ++++
 rtl/column_rasterizer.sv | 175 +++++++++++++++++
 tb/tb_column_rasterizer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rc_pkg
//  Brief    : Shared column-record layout, wall palette and shading helper.
//  Revision : 1.0  initial release
// ============================================================================
package rc_pkg;

    // Column record layout, shared with the DDA sender.
    localparam int COL_W       = 38;
    localparam int HCOUNT_LSB  = 29;
    localparam int HCOUNT_W    = 9;
    localparam int LH_LSB      = 21;
    localparam int LH_W        = 8;
    localparam int SIDE_BIT    = 20;
    localparam int MAP_LSB     = 16;
    localparam int MAP_W       = 4;
    localparam int WALLX_LSB   = 0;
    localparam int WALLX_W     = 16;

    localparam logic [15:0] PALETTE [16] = '{
        16'h0000, 16'hF800, 16'h07E0, 16'h001F,
        16'hFFE0, 16'hF81F, 16'h07FF, 16'hFFFF,
        16'h8410, 16'hFC00, 16'h8000, 16'h0400,
        16'h0010, 16'hC618, 16'hA145, 16'h4208
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } col_state_t;

    // Halve every RGB565 channel; the mask stops bits leaking between fields.
    function automatic logic [15:0] darken(input logic [15:0] c);
        return (c >> 1) & 16'h7BEF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/column_shader.sv
`default_nettype none
// ============================================================================
//  Module   : column_shader
//  Brief    : Combinational ceiling / wall / floor colour for one pixel row.
//  Revision : 1.0  initial release
// ============================================================================
module column_shader
    import rc_pkg::*;
#(
    parameter logic [15:0] CEIL_COLOR  = 16'h39E7,
    parameter logic [15:0] FLOOR_COLOR = 16'h7BEF
) (
    input  logic [7:0]       i_v,
    input  logic [7:0]       i_draw_start,
    input  logic [7:0]       i_draw_end,
    input  logic [MAP_W-1:0] i_map_data,
    input  logic             i_side,
    output logic [15:0]      o_color
);

    logic [15:0] w_wall;

    always_comb begin
        w_wall = PALETTE[i_map_data];
        if (i_side) begin
            w_wall = darken(w_wall);
        end

        // An empty wall has draw_end = draw_start - 1, so rows split cleanly.
        if (i_v < i_draw_start) begin
            o_color = CEIL_COLOR;
        end else if (i_v <= i_draw_end) begin
            o_color = w_wall;
        end else begin
            o_color = FLOOR_COLOR;
        end
    end

endmodule
`default_nettype wire

// File: rtl/column_rasterizer.sv
`default_nettype none
// ============================================================================
//  Module   : column_rasterizer
//  Brief    : Expands column ray records into per-pixel frame buffer writes.
//  Revision : 1.0  initial release
// ============================================================================
module column_rasterizer
    import rc_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 240,
    parameter logic [15:0] CEIL_COLOR    = 16'h39E7,
    parameter logic [15:0] FLOOR_COLOR   = 16'h7BEF
) (
    input  logic             pixel_clk_in,
    input  logic             rst_in,
    input  logic             col_tvalid_in,
    input  logic [COL_W-1:0] col_tdata_in,
    input  logic             col_tlast_in,
    output logic             col_tready_out,
    output logic [16:0]      pix_addr_out,
    output logic [15:0]      pix_data_out,
    output logic             pix_valid_out,
    output logic             pix_last_out
);

    localparam logic [7:0]          c_HEIGHT    = 8'(SCREEN_HEIGHT);
    localparam logic [7:0]          c_LAST_V    = 8'(SCREEN_HEIGHT - 1);
    localparam logic [HCOUNT_W-1:0] c_WIDTH_H   = HCOUNT_W'(SCREEN_WIDTH);
    localparam logic [16:0]         c_ADDR_STEP = 17'(SCREEN_WIDTH);

    col_state_t r_state, w_state_next;

    logic [7:0]       r_v;
    logic [7:0]       r_ds;
    logic [7:0]       r_de;
    logic [MAP_W-1:0] r_map;
    logic             r_side;
    logic             r_tlast;
    logic [16:0]      r_addr;
    logic [15:0]      r_data;
    logic             r_valid;
    logic             r_last;

    logic                w_ready;
    logic                w_xfer;
    logic                w_advance;
    logic [7:0]          w_v_next;
    logic [HCOUNT_W-1:0] w_in_hcount;
    logic [LH_W-1:0]     w_in_lh_raw;
    logic [7:0]          w_in_lh;
    logic [7:0]          w_in_ds;
    logic [7:0]          w_in_de;
    logic                w_in_side;
    logic [MAP_W-1:0]    w_in_map;
    logic                w_in_range;
    logic [7:0]          w_sh_v;
    logic [7:0]          w_sh_ds;
    logic [7:0]          w_sh_de;
    logic [MAP_W-1:0]    w_sh_map;
    logic                w_sh_side;
    logic [15:0]         w_shade;
    logic                w_unused_wallx;

    assign w_in_hcount    = col_tdata_in[HCOUNT_LSB +: HCOUNT_W];
    assign w_in_lh_raw    = col_tdata_in[LH_LSB +: LH_W];
    assign w_in_side      = col_tdata_in[SIDE_BIT];
    assign w_in_map       = col_tdata_in[MAP_LSB +: MAP_W];
    assign w_unused_wallx = ^col_tdata_in[WALLX_LSB +: WALLX_W];

    assign w_in_lh    = (w_in_lh_raw > c_HEIGHT) ? c_HEIGHT : w_in_lh_raw;
    assign w_in_ds    = (c_HEIGHT - w_in_lh) >> 1;
    assign w_in_de    = w_in_ds + w_in_lh - 8'd1;
    assign w_in_range = (w_in_hcount < c_WIDTH_H);

    assign col_tready_out = w_ready && !rst_in;
    assign w_xfer         = col_tvalid_in && col_tready_out;
    assign w_advance      = (r_state == ST_DRAW) && (r_v != c_LAST_V);
    assign w_v_next       = r_v + 8'd1;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = 1'b1;
            ST_DRAW: w_ready = (r_v == c_LAST_V);
            default: w_ready = 1'b0;
        endcase
        if (w_xfer) begin
            w_state_next = w_in_range ? ST_DRAW : ST_IDLE;
        end else if ((r_state == ST_DRAW) && (r_v == c_LAST_V)) begin
            w_state_next = ST_IDLE;
        end
    end

    // The output registers hold pixel r_v, so the shader always looks one row
    // ahead: row 0 of the incoming record on accept, otherwise row r_v + 1.
    assign w_sh_v    = w_xfer ? 8'd0     : w_v_next;
    assign w_sh_ds   = w_xfer ? w_in_ds   : r_ds;
    assign w_sh_de   = w_xfer ? w_in_de   : r_de;
    assign w_sh_map  = w_xfer ? w_in_map  : r_map;
    assign w_sh_side = w_xfer ? w_in_side : r_side;

    column_shader #(
        .CEIL_COLOR  (CEIL_COLOR),
        .FLOOR_COLOR (FLOOR_COLOR)
    ) u_shader (
        .i_v          (w_sh_v),
        .i_draw_start (w_sh_ds),
        .i_draw_end   (w_sh_de),
        .i_map_data   (w_sh_map),
        .i_side       (w_sh_side),
        .o_color      (w_shade)
    );

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_v     <= '0;
            r_ds    <= '0;
            r_de    <= '0;
            r_map   <= '0;
            r_side  <= 1'b0;
            r_tlast <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_xfer) begin
            r_v     <= '0;
            r_ds    <= w_in_ds;
            r_de    <= w_in_de;
            r_map   <= w_in_map;
            r_side  <= w_in_side;
            r_tlast <= col_tlast_in;
            if (w_in_range) begin
                r_addr  <= {{(17 - HCOUNT_W){1'b0}}, w_in_hcount};
                r_data  <= w_shade;
                r_valid <= 1'b1;
                r_last  <= col_tlast_in && (c_LAST_V == 8'd0);
            end else begin
                // Off-screen column: consumed silently, only the frame marker survives.
                r_addr  <= '0;
                r_data  <= '0;
                r_valid <= 1'b0;
                r_last  <= col_tlast_in;
            end
        end else if (w_advance) begin
            r_v     <= w_v_next;
            r_addr  <= r_addr + c_ADDR_STEP;
            r_data  <= w_shade;
            r_valid <= 1'b1;
            r_last  <= r_tlast && (w_v_next == c_LAST_V);
        end else begin
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign pix_addr_out  = r_addr;
    assign pix_data_out  = r_data;
    assign pix_valid_out = r_valid;
    assign pix_last_out  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_column_rasterizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_column_rasterizer
//  Brief    : Directed self-checking bench for column_rasterizer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_column_rasterizer;

    localparam logic [15:0] c_CEIL  = 16'h39E7;
    localparam logic [15:0] c_FLOOR = 16'h7BEF;

    logic        clk;
    logic        rst;
    logic        col_tvalid;
    logic [37:0] col_tdata;
    logic        col_tlast;
    logic        col_tready;
    logic [16:0] pix_addr;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_last;

    int checks   = 0;
    int failures = 0;
    int last_cnt = 0;

    column_rasterizer u_dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst),
        .col_tvalid_in  (col_tvalid),
        .col_tdata_in   (col_tdata),
        .col_tlast_in   (col_tlast),
        .col_tready_out (col_tready),
        .pix_addr_out   (pix_addr),
        .pix_data_out   (pix_data),
        .pix_valid_out  (pix_valid),
        .pix_last_out   (pix_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] rec(input int hc, input int lh, input bit side,
                                        input int map);
        logic [8:0] h;
        logic [7:0] l;
        logic [3:0] m;
        h = 9'(hc);
        l = 8'(lh);
        m = 4'(map);
        return {h, l, side, m, 16'hABCD};
    endfunction

    task automatic expect_idle(input string name, input logic exp_ready);
        checks++;
        if (pix_valid !== 1'b0 || pix_last !== 1'b0 || pix_addr !== 17'd0 ||
            pix_data !== 16'd0 || col_tready !== exp_ready) begin
            failures++;
            $display("FAIL %s: valid=%b last=%b addr=%0d data=%h ready=%b, required 0/0/0/0000/%b",
                     name, pix_valid, pix_last, pix_addr, pix_data, col_tready, exp_ready);
        end
    endtask

    // Entered with pixel v=0 on the outputs; returns with pixel v=239 on them.
    task automatic check_column(input string name, input int hc, input int ds, input int de,
                                input logic [15:0] wall, input bit tlast);
        logic [15:0] exp_c;
        int          bad;
        bad = 0;
        for (int v = 0; v < 240; v++) begin
            if (v > 0) step();
            exp_c = (v < ds) ? c_CEIL : ((v <= de) ? wall : c_FLOOR);
            if (pix_last === 1'b1) last_cnt++;
            checks++;
            if (pix_valid !== 1'b1 || pix_addr !== 17'(hc + 320 * v) || pix_data !== exp_c ||
                pix_last !== (tlast && v == 239) || col_tready !== (v == 239)) begin
                failures++;
                bad++;
                if (bad <= 8)
                    $display("FAIL %s v=%0d: valid=%b addr=%0d data=%h last=%b ready=%b, required 1/%0d/%h/%b/%b",
                             name, v, pix_valid, pix_addr, pix_data, pix_last, col_tready,
                             hc + 320 * v, exp_c, (tlast && v == 239), (v == 239));
            end
        end
    endtask

    task automatic send_single(input string name, input int hc, input int lh, input bit side,
                               input int map, input int ds, input int de,
                               input logic [15:0] wall);
        expect_idle({name, "_pre"}, 1'b1);
        col_tvalid = 1'b1;
        col_tdata  = rec(hc, lh, side, map);
        col_tlast  = 1'b0;
        step();
        col_tvalid = 1'b0;
        check_column(name, hc, ds, de, wall, 1'b0);
        step();
        expect_idle({name, "_post"}, 1'b1);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        col_tvalid = 1'b1;
        col_tdata  = rec(1, 50, 0, 1);
        col_tlast  = 1'b1;
        step();
        step();
        expect_idle("reset_hold", 1'b0);
        col_tvalid = 1'b0;
        col_tlast  = 1'b0;
        rst        = 1'b0;
        #1;
        expect_idle("reset_release", 1'b1);
    endtask

    task automatic test_columns();
        send_single("col_lh100", 5, 100, 1'b0, 3, 70, 169, 16'h001F);
        send_single("col_lh101_dark", 7, 101, 1'b1, 2, 69, 169, 16'h03E0);
        send_single("col_lh0", 10, 0, 1'b0, 1, 120, 119, 16'hF800);
        send_single("col_lh250", 11, 250, 1'b0, 4, 0, 239, 16'hFFE0);
    endtask

    task automatic test_back_to_back();
        last_cnt   = 0;
        col_tvalid = 1'b1;
        col_tdata  = rec(318, 100, 0, 3);
        col_tlast  = 1'b0;
        step();
        col_tdata  = rec(319, 100, 0, 3);
        col_tlast  = 1'b1;
        check_column("b2b_first", 318, 70, 169, 16'h001F, 1'b0);
        step();
        col_tvalid = 1'b0;
        col_tlast  = 1'b0;
        check_column("b2b_second", 319, 70, 169, 16'h001F, 1'b1);
        checks++;
        if (pix_addr !== 17'd76799 || pix_last !== 1'b1) begin
            failures++;
            $display("FAIL b2b_last_addr: addr=%0d last=%b, required 76799/1", pix_addr, pix_last);
        end
        step();
        expect_idle("b2b_post", 1'b1);
        checks++;
        if (last_cnt !== 1) begin
            failures++;
            $display("FAIL b2b_last_count: saw %0d pulses, required 1", last_cnt);
        end
    endtask

    task automatic test_dropped();
        col_tvalid = 1'b1;
        col_tdata  = rec(400, 100, 0, 3);
        col_tlast  = 1'b1;
        step();
        col_tvalid = 1'b0;
        col_tlast  = 1'b0;
        checks++;
        if (pix_valid !== 1'b0 || pix_last !== 1'b1 || col_tready !== 1'b1) begin
            failures++;
            $display("FAIL drop_pulse: valid=%b last=%b ready=%b, required 0/1/1",
                     pix_valid, pix_last, col_tready);
        end
        step();
        expect_idle("drop_after", 1'b1);
        step();
        expect_idle("drop_after2", 1'b1);
    endtask

    task automatic test_reset_mid();
        col_tvalid = 1'b1;
        col_tdata  = rec(20, 100, 0, 3);
        col_tlast  = 1'b1;
        step();
        col_tvalid = 1'b0;
        col_tlast  = 1'b0;
        for (int v = 1; v < 50; v++) step();
        checks++;
        if (pix_valid !== 1'b1 || pix_addr !== 17'(20 + 320 * 49) || pix_data !== c_CEIL) begin
            failures++;
            $display("FAIL mid_pixel49: valid=%b addr=%0d data=%h, required 1/%0d/%h",
                     pix_valid, pix_addr, pix_data, 20 + 320 * 49, c_CEIL);
        end
        rst = 1'b1;
        step();
        expect_idle("mid_reset1", 1'b0);
        step();
        expect_idle("mid_reset2", 1'b0);
        rst = 1'b0;
        #1;
        expect_idle("mid_release", 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_idle("mid_abandoned", 1'b1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        col_tvalid = 1'b0;
        col_tdata  = '0;
        col_tlast  = 1'b0;
        test_reset();
        test_columns();
        test_back_to_back();
        test_dropped();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
